fetch_queue: RTL
================

# fetch_queue

Instruction fetch queue between the IF stage (imem + branch predictor) and the IF/ID pipeline register. It buffers fetched {pc, npc, instr} triples in a first-word-fall-through FIFO so fetch can keep running while ID is stalled. On a redirect (C_JUMP/C_FLUSH) it discards all buffered wrong-path entries in one cycle. When empty, it presents an all-zero bubble (instr 0 = nop) to ID.

## Interface
- DWIDTH, 32, width of pc, npc and instr
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- push_valid  input  1  IF offers a fetched instruction this cycle
- push_ready  output  1  queue accepts a push this cycle
- push_pc  input  DWIDTH  pc of the offered instruction
- push_npc  input  DWIDTH  predicted next pc
- push_instr  input  DWIDTH  instruction word
- pop_valid  output  1  head entry valid
- pop_ready  input  1  ID consumes the head this cycle
- pop_pc  output  DWIDTH  head pc; 0 when pop_valid=0
- pop_npc  output  DWIDTH  head npc; 0 when pop_valid=0
- pop_instr  output  DWIDTH  head instr; 0 when pop_valid=0
- flush  input  1  discard all entries, synchronous
- count  output  $clog2(DEPTH+1)  number of valid entries

## Operation
- Storage: DEPTH-entry register array; read pointer rp and write pointer wp, each log2(DEPTH) bits wide, wrap modulo DEPTH; occupancy counter cnt, 0..DEPTH.
- push_ready = (cnt != DEPTH). No pop-side bypass: when full, a same-cycle pop does not enable a push.
- pop_valid = (cnt != 0). Head data comes combinationally from entry[rp] and is forced to 0 when empty.
- Push fire = push_valid & push_ready & ~flush: write entry[wp], wp += 1.
- Pop fire = pop_valid & pop_ready: rp += 1.
- cnt update: +1 on push only; −1 on pop only; unchanged when both fire.
- Flush (highest priority): rp = wp = cnt = 0 at the next edge. A push offered in the flush cycle is dropped. A pop asserted in the flush cycle is treated as consumed, and the entry is gone either way.
- Push when full: push_ready=0; no state change; IF holds its offer.
- Pop when empty: ignored; pointers and cnt unchanged.
- Entry contents are not cleared by flush or pop. The zero forcing on the outputs hides stale data.
- count = cnt.

## Timing
- Reset (rst=0, asynchronous): rp=wp=cnt=0 immediately. Outputs: pop_valid=0, push_ready=1, count=0, pop_pc=pop_npc=pop_instr=0. Entry array reset to 0.
- Release is synchronous to clk. The first push is accepted on the first rising edge with rst=1.
- Latency: data pushed at edge k is visible on pop_* with pop_valid=1 after edge k, so ID can latch it at edge k+1. There is no same-cycle push→pop path.
- Throughput: one push and one pop per cycle sustained when 0 < cnt < DEPTH.
- Flush at edge k: after edge k, pop_valid=0, push_ready=1, count=0. The first post-flush push is accepted at edge k+1.
- Reset asserted mid-operation: all state clears asynchronously and the same reset output values hold until release. Buffered entries are lost.

## Test plan
- Reset/idle: hold rst=0, then release with no traffic → pop_valid=0, push_ready=1, count=0, pop_instr=0 every cycle.
- Fill and drain: push pc=0x0,0x4,0x8,0xC (instr 0x20080001..4) with pop_ready=0 → count=4, push_ready=0. A fifth push of pc=0x10 is held off. Then set pop_ready=1 → pops appear in order 0x0..0xC, one per cycle, and pc=0x10 is accepted only once cnt<4.
- Wrap-around: stream 10 pushes with pop_ready=1 throughout, starting pc=0x40 → outputs 0x40..0x64 in order, count toggles 0/1, no loss or duplication as pointers pass DEPTH.
- Full with simultaneous pop: cnt=4, push_valid=1, pop_ready=1 → push_ready=0. The head pops, count=3 after the edge, and the push is accepted the next cycle.
- Flush with push and pop: cnt=2, assert flush with push_valid=1 (pc=0x80) and pop_ready=1 → after the edge count=0, pop_valid=0, and 0x80 never appears. Pushing pc=0x100 next cycle → pop_pc=0x100 one cycle later.
- Async reset mid-stream: cnt=3, drop rst between edges → pop_valid=0 and count=0 before the next clk edge. After release, the first output is the first new push.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch queue: FWFT buffer of {pc, npc, instr} between IF and the IF/ID register.
// A flush drops every buffered entry in one cycle. An empty queue presents an all-zero bubble.
module fetch_queue #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [DWIDTH-1:0]          push_pc,
  input  logic [DWIDTH-1:0]          push_npc,
  input  logic [DWIDTH-1:0]          push_instr,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [DWIDTH-1:0]          pop_pc,
  output logic [DWIDTH-1:0]          pop_npc,
  output logic [DWIDTH-1:0]          pop_instr,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DWIDTH-1:0] pc_q    [DEPTH];
  logic [DWIDTH-1:0] npc_q   [DEPTH];
  logic [DWIDTH-1:0] instr_q [DEPTH];

  logic [AW-1:0] rp_q, rp_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic push_fire;
  logic pop_fire;

  // No pop-side bypass: a full queue refuses pushes even while popping.
  assign push_ready = (cnt_q != CW'(DEPTH));
  assign pop_valid  = (cnt_q != '0);
  assign push_fire  = push_valid & push_ready & ~flush;
  assign pop_fire   = pop_valid & pop_ready;
  assign count      = cnt_q;

  assign pop_pc    = pop_valid ? pc_q[rp_q]    : '0;
  assign pop_npc   = pop_valid ? npc_q[rp_q]   : '0;
  assign pop_instr = pop_valid ? instr_q[rp_q] : '0;

  always_comb begin
    rp_d  = rp_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (flush) begin
      rp_d  = '0;
      wp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_fire) wp_d = wp_q + AW'(1);
      if (pop_fire)  rp_d = rp_q + AW'(1);
      if (push_fire && !pop_fire)      cnt_d = cnt_q + CW'(1);
      else if (pop_fire && !push_fire) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        npc_q[i]   <= '0;
        instr_q[i] <= '0;
      end
    end else if (push_fire) begin
      pc_q[wp_q]    <= push_pc;
      npc_q[wp_q]   <= push_npc;
      instr_q[wp_q] <= push_instr;
    end
  end

endmodule
